// File: rtl/mem_lsu.sv
// MEM stage of the RV32I pipeline: data-memory bus master (req/gnt + rvalid),
// store lane placement, load extraction/extension, upstream stall and MEM/WB register.
module mem_lsu #(
  parameter int unsigned DMEM_AW = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [31:0]        alu_mem_i,
  input  logic [31:0]        rs2_mem_i,
  input  logic [31:0]        pc4_mem_i,
  input  logic               MemRW_mem_i,
  input  logic [1:0]         WBSel_mem_i,
  input  logic               RegWEn_mem_i,
  input  logic [4:0]         rsW_mem_i,
  input  logic [31:0]        inst_mem_i,
  input  logic               enable_i,
  input  logic               reset_i,
  output logic               dmem_req_o,
  output logic               dmem_we_o,
  output logic [DMEM_AW-1:0] dmem_addr_o,
  output logic [3:0]         dmem_be_o,
  output logic [31:0]        dmem_wdata_o,
  input  logic               dmem_gnt_i,
  input  logic               dmem_rvalid_i,
  input  logic [31:0]        dmem_rdata_i,
  output logic               stall_o,
  output logic               misaligned_o,
  output logic [31:0]        alu_wb_o,
  output logic [31:0]        mem_wb_o,
  output logic [31:0]        pc4_wb_o,
  output logic [31:0]        inst_wb_o,
  output logic [1:0]         WBSel_wb_o,
  output logic               RegWEn_wb_o,
  output logic [4:0]         rsW_wb_o
);

  typedef enum logic [1:0] {IDLE, WAIT_R, HOLD} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic [1:0]  wbsel;
    logic        regwen;
    logic [4:0]  rsw;
  } memwb_t;

  // Undefined funct3 encodings fall through to a word access.
  function automatic size_e acc_size(input logic [2:0] f3, input logic is_st);
    if (f3 == 3'b000 || (!is_st && f3 == 3'b100)) return SZ_B;
    if (f3 == 3'b001 || (!is_st && f3 == 3'b101)) return SZ_H;
    return SZ_W;
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (acc_size(f3, 1'b0))
      SZ_B:    return f3[2] ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_H:    return f3[2] ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return word;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] resp_q, resp_d;
  memwb_t      memwb_q, memwb_d;

  logic        is_store, is_load, is_access, misalign;
  size_e       size;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        req, stall, mis_flag;
  logic [31:0] wb_mem;

  always_comb begin
    is_store  = MemRW_mem_i;
    is_load   = ~MemRW_mem_i & RegWEn_mem_i & (WBSel_mem_i == 2'b00);
    is_access = is_store | is_load;
    size      = acc_size(inst_mem_i[14:12], is_store);
    misalign  = is_access & (((size == SZ_H) && alu_mem_i[0]) ||
                             ((size == SZ_W) && (alu_mem_i[1:0] != 2'b00)));
  end

  always_comb begin
    be    = 4'b1111;
    wdata = '0;
    if (is_store) begin
      case (size)
        SZ_B: begin
          be    = 4'b0001 << alu_mem_i[1:0];
          wdata = {4{rs2_mem_i[7:0]}};
        end
        SZ_H: begin
          be    = 4'b0011 << alu_mem_i[1:0];
          wdata = {2{rs2_mem_i[15:0]}};
        end
        default: wdata = rs2_mem_i;
      endcase
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d  = state_q;
    f3_d     = f3_q;
    off_d    = off_q;
    resp_d   = resp_q;
    req      = 1'b0;
    stall    = 1'b0;
    mis_flag = 1'b0;
    wb_mem   = '0;
    case (state_q)
      IDLE: begin
        if (is_access) begin
          if (misalign) begin
            mis_flag = 1'b1;
          end else begin
            req = 1'b1;
            if (is_store) begin
              stall = ~dmem_gnt_i;
            end else begin
              stall = 1'b1;
              if (dmem_gnt_i) begin
                f3_d    = inst_mem_i[14:12];
                off_d   = alu_mem_i[1:0];
                state_d = WAIT_R;
              end
            end
          end
        end
      end
      WAIT_R: begin
        stall = 1'b1;
        if (dmem_rvalid_i) begin
          if (enable_i) begin
            stall   = 1'b0;
            wb_mem  = load_ext(f3_q, off_q, dmem_rdata_i);
            state_d = IDLE;
          end else begin
            resp_d  = load_ext(f3_q, off_q, dmem_rdata_i);
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        stall = 1'b1;
        if (enable_i) begin
          stall   = 1'b0;
          wb_mem  = resp_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A stalled or misaligned cycle retires nothing, so MEM/WB takes an all-zero bubble.
  always_comb begin
    memwb_d = memwb_q;
    if (enable_i) begin
      if (reset_i || stall || mis_flag) begin
        memwb_d = '0;
      end else begin
        memwb_d.alu    = alu_mem_i;
        memwb_d.mem    = wb_mem;
        memwb_d.pc4    = pc4_mem_i;
        memwb_d.inst   = inst_mem_i;
        memwb_d.wbsel  = WBSel_mem_i;
        memwb_d.regwen = RegWEn_mem_i;
        memwb_d.rsw    = rsW_mem_i;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      f3_q    <= '0;
      off_q   <= '0;
      resp_q  <= '0;
      memwb_q <= '0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      resp_q  <= resp_d;
      memwb_q <= memwb_d;
    end
  end

  // Bus and control outputs are forced low while reset is held.
  assign dmem_req_o   = rst_ni & req;
  assign dmem_we_o    = rst_ni & is_store;
  assign dmem_addr_o  = rst_ni ? {alu_mem_i[DMEM_AW-1:2], 2'b00} : '0;
  assign dmem_be_o    = rst_ni ? be : 4'b0000;
  assign dmem_wdata_o = rst_ni ? wdata : '0;
  assign stall_o      = rst_ni & stall;
  assign misaligned_o = rst_ni & mis_flag;

  assign alu_wb_o    = memwb_q.alu;
  assign mem_wb_o    = memwb_q.mem;
  assign pc4_wb_o    = memwb_q.pc4;
  assign inst_wb_o   = memwb_q.inst;
  assign WBSel_wb_o  = memwb_q.wbsel;
  assign RegWEn_wb_o = memwb_q.regwen;
  assign rsW_wb_o    = memwb_q.rsw;

endmodule
